// File: rtl/dtc_pkg.sv
// Shared types and helpers for the decision-tree classifier scheduler.
// Holds the FSM state enum, default widths and the round-robin pick function.
package dtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FEAT_W_DEF  = 12;
    localparam int CLASS_W_DEF = 3;
    localparam int MAX_REQ     = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First set bit of valid[n-1:0] searching ptr, ptr+1, ... with wrap.
    // Walks offsets high to low so the smallest offset is written last.
    function automatic pick_t rr_pick(
        input logic [15:0] valid,
        input logic [3:0]  ptr,
        input int          n
    );
        pick_t r;
        int    j;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (valid[j[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dtc_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and index from valid/ptr.
// Ports: valid, ptr in; found, grant (one-hot or zero), idx out.
module dtc_rr_arbiter
    import dtc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(16'(valid), 4'(ptr), NUM_REQ);
        found = pick.found;
        idx   = ID_W'(pick.idx);
        grant = '0;
        if (pick.found) begin
            grant = NUM_REQ'(1) << pick.idx;
        end
    end

endmodule

// File: rtl/dtc_rr_scheduler.sv
// Shares one external combinational classifier among NUM_REQ requesters.
// Ports: clk, rst_n; req_valid/req_ready/req_feat per requester;
// cls_feat/cls_class to the classifier; rsp_valid/rsp_ready/rsp_class/
// rsp_id response side; served_cnt saturating completed-response count.
module dtc_rr_scheduler
    import dtc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int CLASS_W = CLASS_W_DEF,
    parameter int CNT_W   = 16,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FEAT_W-1:0] req_feat,
    output logic [FEAT_W-1:0]         cls_feat,
    input  logic [CLASS_W-1:0]        cls_class,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [CLASS_W-1:0]        rsp_class,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          served_cnt
);

    state_t             state;
    state_t             state_nx;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_nx;
    logic [ID_W-1:0]    id_reg;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic [FEAT_W-1:0]  win_feat;
    logic               accept;
    logic               done;

    dtc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .found (found),
        .grant (grant),
        .idx   (win_idx)
    );

    assign win_feat = req_feat[win_idx*FEAT_W +: FEAT_W];
    assign accept   = (state == IDLE) && found;
    assign done     = (state == RESP) && rsp_ready;

    // Start after the requester just served; wraps at NUM_REQ-1.
    assign ptr_nx = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready = grant;
                    state_nx  = EVAL;
                end
            end
            EVAL: begin
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            id_reg     <= '0;
            cls_feat   <= '0;
            rsp_class  <= '0;
            rsp_id     <= '0;
            served_cnt <= '0;
        end else begin
            if (accept) begin
                cls_feat <= win_feat;
                id_reg   <= win_idx;
            end
            if (state == EVAL) begin
                rsp_class <= cls_class;
                rsp_id    <= id_reg;
            end
            if (done) begin
                ptr <= ptr_nx;
                if (served_cnt != '1) begin
                    served_cnt <= served_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dtc_rr_scheduler.sv
// Directed bench for dtc_rr_scheduler with a cls = feat[2:0] classifier.
// Runs a transaction table then backpressure, reset and streaming sequences.
module tb_dtc_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_feat;
    logic [11:0] cls_feat;
    logic [2:0]  cls_class;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_class;
    logic [1:0]  rsp_id;
    logic [1:0]  served_cnt;

    int nvec;
    int nerr;
    int cnt_m;

    dtc_rr_scheduler #(
        .NUM_REQ (4),
        .FEAT_W  (12),
        .CLASS_W (3),
        .CNT_W   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_feat   (req_feat),
        .cls_feat   (cls_feat),
        .cls_class  (cls_class),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_class  (rsp_class),
        .rsp_id     (rsp_id),
        .served_cnt (served_cnt)
    );

    assign cls_class = cls_feat[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [47:0] feats;
        logic [3:0]  grant;
        logic [1:0]  id;
        logic [2:0]  cls;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        logic [11:0] ef;
        ef = 12'(tbl[i].feats >> (32'(tbl[i].id) * 12));
        @(negedge clk);
        req_valid = tbl[i].valid;
        req_feat  = tbl[i].feats;
        rsp_ready = 1'b1;
        #1;
        chk($sformatf("v%0d grant", i), 64'(req_ready), 64'(tbl[i].grant));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk($sformatf("v%0d eval_rdy", i), 64'(req_ready), 64'(0));
        chk($sformatf("v%0d cls_feat", i), 64'(cls_feat), 64'(ef));
        @(negedge clk);
        chk($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'(1));
        chk($sformatf("v%0d rsp_class", i), 64'(rsp_class), 64'(tbl[i].cls));
        chk($sformatf("v%0d rsp_id", i), 64'(rsp_id), 64'(tbl[i].id));
        @(negedge clk);
        if (cnt_m < 3) cnt_m++;
        chk($sformatf("v%0d idle", i), 64'(rsp_valid), 64'(0));
        chk($sformatf("v%0d cnt", i), 64'(served_cnt), 64'(cnt_m));
        chk($sformatf("v%0d feat_hold", i), 64'(cls_feat), 64'(ef));
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        cnt_m = 0;

        tbl[0] = '{4'b0001, {12'h0, 12'h0, 12'h0, 12'h005},
                   4'b0001, 2'd0, 3'd5};
        tbl[1] = '{4'b1000, {12'h00e, 12'h0, 12'h0, 12'h0},
                   4'b1000, 2'd3, 3'd6};
        tbl[2] = '{4'b1001, {12'h007, 12'h0, 12'h0, 12'h003},
                   4'b0001, 2'd0, 3'd3};
        tbl[3] = '{4'b1001, {12'h007, 12'h0, 12'h0, 12'h003},
                   4'b1000, 2'd3, 3'd7};
        tbl[4] = '{4'b0110, {12'h0, 12'h0f4, 12'h0a2, 12'h0},
                   4'b0010, 2'd1, 3'd2};
        tbl[5] = '{4'b0110, {12'h0, 12'h0f4, 12'h0a2, 12'h0},
                   4'b0100, 2'd2, 3'd4};
        tbl[6] = '{4'b0011, {12'h0, 12'h0, 12'h000, 12'h001},
                   4'b0001, 2'd0, 3'd1};
        tbl[7] = '{4'b0011, {12'h0, 12'h0, 12'h000, 12'h001},
                   4'b0010, 2'd1, 3'd0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_feat  = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst req_ready", 64'(req_ready), 64'(0));
        chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst rsp_class", 64'(rsp_class), 64'(0));
        chk("rst rsp_id", 64'(rsp_id), 64'(0));
        chk("rst cls_feat", 64'(cls_feat), 64'(0));
        chk("rst served_cnt", 64'(served_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Backpressure: ptr is 2 after the table.
        @(negedge clk);
        req_valid = 4'b0100;
        req_feat  = {12'h0, 12'h003, 12'h0, 12'h0};
        rsp_ready = 1'b0;
        #1;
        chk("bp grant", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        chk("bp rsp_valid", 64'(rsp_valid), 64'(1));
        chk("bp rsp_class", 64'(rsp_class), 64'(3));
        chk("bp rsp_id", 64'(rsp_id), 64'(2));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d valid", k), 64'(rsp_valid), 64'(1));
            chk($sformatf("bp%0d class", k), 64'(rsp_class), 64'(3));
            chk($sformatf("bp%0d id", k), 64'(rsp_id), 64'(2));
            chk($sformatf("bp%0d rdy", k), 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp done", 64'(rsp_valid), 64'(0));
        chk("bp next grant", 64'(req_ready), 64'(4'b1000));
        chk("bp cnt", 64'(served_cnt), 64'(3));
        req_valid = '0;

        // Asynchronous reset while in EVAL.
        @(negedge clk);
        req_valid = 4'b0010;
        req_feat  = {12'h0, 12'h0, 12'h005, 12'h0};
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("re cls_feat", 64'(cls_feat), 64'(5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("re rsp_valid", 64'(rsp_valid), 64'(0));
        chk("re cnt", 64'(served_cnt), 64'(0));
        chk("re cls_feat0", 64'(cls_feat), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("re%0d no_rsp", k), 64'(rsp_valid), 64'(0));
        end

        // Streaming: all four valid, ptr reset to 0, feat_i = i+1.
        cnt_m = 0;
        @(negedge clk);
        req_valid = 4'b1111;
        req_feat  = {12'h004, 12'h003, 12'h002, 12'h001};
        for (int n = 0; n <= 15; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (n == 15) begin
                chk("st end valid", 64'(rsp_valid), 64'(0));
                chk("st end cnt", 64'(served_cnt), 64'(3));
            end else if (n % 3 == 2) begin
                chk($sformatf("st%0d valid", n), 64'(rsp_valid), 64'(1));
                chk($sformatf("st%0d id", n), 64'(rsp_id),
                    64'((n / 3) % 4));
                chk($sformatf("st%0d class", n), 64'(rsp_class),
                    64'((n / 3) % 4 + 1));
                if (n == 14) req_valid = '0;
            end else if (n % 3 == 0) begin
                chk($sformatf("st%0d grant", n), 64'(req_ready),
                    64'(4'b0001 << ((n / 3) % 4)));
                if (n > 0) begin
                    if (cnt_m < 3) cnt_m++;
                    chk($sformatf("st%0d cnt", n), 64'(served_cnt),
                        64'(cnt_m));
                end
            end else begin
                chk($sformatf("st%0d valid", n), 64'(rsp_valid), 64'(0));
                chk($sformatf("st%0d rdy", n), 64'(req_ready), 64'(0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
